// File: rtl/flex_stp_rx.sv
// rtl/flex_stp_rx.sv - serial-to-parallel word assembler with valid/ready output buffer
//
// Purpose:
//   Samples one recovered bit per shift_enable strobe, assembles NUM_BITS-wide
//   words and hands each completed word to a small valid/ready output buffer.
//   A completed word that finds the buffer full is dropped and the sticky
//   overrun flag is raised.
//
// Build option:
//   FLEX_STP_SKID_EN  defined   -> 2-entry FIFO output buffer (states EMPTY/ONE/TWO)
//                     undefined -> 1-entry output buffer (states EMPTY/ONE)
//
// Parameters:
//   NUM_BITS   word width (>= 2)
//   SHIFT_MSB  1: first received bit lands in data_out[NUM_BITS-1]
//              0: first received bit lands in data_out[0]
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   shift_enable   sample serial_in this cycle
//   serial_in      recovered data bit
//   frame_reset    synchronous clear of the partial word
//   data_ready     consumer accepts data_out this cycle
//   clear_overrun  synchronous clear of overrun
//   data_out       oldest buffered word
//   data_valid     data_out holds an unconsumed word
//   bit_count      bits held in the partial word
//   overrun        sticky, a completed word was dropped

module flex_stp_rx #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_enable,
  input  logic                        serial_in,
  input  logic                        frame_reset,
  input  logic                        data_ready,
  input  logic                        clear_overrun,
  output logic [NUM_BITS-1:0]         data_out,
  output logic                        data_valid,
  output logic [$clog2(NUM_BITS)-1:0] bit_count,
  output logic                        overrun
);

  localparam int            CW       = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  // Bit 0 means "head entry holds a word" so data_valid is a plain flop bit;
  // bit 1 means "skid entry holds a word".
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } buf_state_t;

  buf_state_t          state_q;
  buf_state_t          state_d;
  logic [NUM_BITS-1:0] shift_reg;
  logic [NUM_BITS-1:0] next_word;
  logic                push;
  logic                pop;
  logic                drop;
  logic                ld_head_word;
`ifdef FLEX_STP_SKID_EN
  logic [NUM_BITS-1:0] skid_q;
  logic                ld_head_skid;
  logic                ld_skid;
`endif

  // Word as it looks after the current bit is shifted in; this is both the
  // next shift register value and the value pushed on word completion.
  if (SHIFT_MSB != 0) begin : g_shift_msb
    assign next_word = {shift_reg[NUM_BITS-2:0], serial_in};
  end else begin : g_shift_lsb
    assign next_word = {serial_in, shift_reg[NUM_BITS-1:1]};
  end

  // frame_reset suppresses the strobe, so a coincident bit never completes a word.
  assign push = shift_enable && !frame_reset && (bit_count == LAST_BIT);
  assign pop  = state_q[0] && data_ready;

  // ---------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '1;
      bit_count <= '0;
    end else if (frame_reset) begin
      shift_reg <= '1;
      bit_count <= '0;
    end else if (shift_enable) begin
      if (bit_count == LAST_BIT) begin
        shift_reg <= '1;
        bit_count <= '0;
      end else begin
        shift_reg <= next_word;
        bit_count <= bit_count + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (pop && !push) state_d = ST_EMPTY;
`ifdef FLEX_STP_SKID_EN
        else if (push && !pop) state_d = ST_TWO;
`endif
      end
`ifdef FLEX_STP_SKID_EN
      ST_TWO: begin
        if (pop && !push) state_d = ST_ONE;
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output buffer FSM: outputs and entry load controls
  // ---------------------------------------------------------------------
  always_comb begin
    data_valid   = state_q[0];
    ld_head_word = 1'b0;
    drop         = 1'b0;
`ifdef FLEX_STP_SKID_EN
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
`endif
    case (state_q)
      ST_EMPTY: begin
        ld_head_word = push;
      end
      ST_ONE: begin
        // A pop frees the head in the same cycle, so the new word goes straight in.
        ld_head_word = push && pop;
`ifdef FLEX_STP_SKID_EN
        ld_skid      = push && !pop;
`else
        drop         = push && !pop;
`endif
      end
`ifdef FLEX_STP_SKID_EN
      ST_TWO: begin
        // Skid entry advances to head on pop; a coincident push refills the skid.
        ld_head_skid = pop;
        ld_skid      = push && pop;
        drop         = push && !pop;
      end
`endif
      default: begin
        ld_head_word = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Buffer storage and sticky overrun
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '1;
    end else if (ld_head_word) begin
      data_out <= next_word;
    end
`ifdef FLEX_STP_SKID_EN
    else if (ld_head_skid) begin
      data_out <= skid_q;
    end
`endif
  end

`ifdef FLEX_STP_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '1;
    end else if (ld_skid) begin
      skid_q <= next_word;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/flex_stp_rx.md
# flex_stp_rx

Receive-side counterpart of the transmitter's parallel-to-serial shifter: a parameterised serial-to-parallel word assembler. It samples one serial bit per `shift_enable` strobe and counts bits. Each completed `NUM_BITS` word is handed to a valid/ready output buffer, with sticky overrun detection. It sits between the receiver's bit-recovery logic (sync/decode/unstuff) and the packet-level receive controller.

## Interface
- `NUM_BITS`, default 8: word width, ≥ 2.
- `SHIFT_MSB`, default 1: 1 = first received bit lands in `data_out[NUM_BITS-1]`; 0 = first received bit lands in `data_out[0]`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `shift_enable`  in  1  sample `serial_in` this cycle.
- `serial_in`  in  1  recovered data bit.
- `frame_reset`  in  1  synchronous clear of the partial word (sync/EOP boundary).
- `data_ready`  in  1  consumer accepts `data_out` this cycle.
- `clear_overrun`  in  1  synchronous clear of `overrun`.
- `data_out`  out  NUM_BITS  oldest buffered word.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `bit_count`  out  $clog2(NUM_BITS)  bits held in the partial word.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Shift register (internal, `NUM_BITS`):
  - resets to all ones (idle-line value).
  - With `SHIFT_MSB`=1, each strobe shifts left and inserts `serial_in` at bit 0.
  - With `SHIFT_MSB`=0, each strobe shifts right and inserts `serial_in` at bit `NUM_BITS-1`.
- Bit counter:
  - increments on each strobe.
  - On a strobe with `bit_count == NUM_BITS-1` the word completes. The assembled word, including the current bit, is pushed to the output buffer, the counter wraps to 0, and the shift register is reloaded with all ones.
- `frame_reset`:
  - clears the counter to 0 and sets the shift register to all ones.
  - Wins over a coincident `shift_enable`: that bit is discarded and no word completes.
  - Does not touch the output buffer or `overrun`.
- Output buffer:
  - Pop occurs when `data_valid && data_ready`.
  - Push occurs on word completion.
  - When the buffer is full and there is no coincident pop, a push is dropped. Buffer contents are unchanged and `overrun` is set.
  - When a push and a pop coincide on a full buffer, both take effect and no overrun is flagged.
- Overrun:
  - `clear_overrun` clears `overrun`.
  - If clear and a new overrun coincide, the set wins.
- Output buffer FSM:
  - states EMPTY, ONE, TWO; TWO exists only when the skid option is enabled.
  - EMPTY→ONE on push.
  - ONE→EMPTY on pop without push.
  - ONE→TWO on push without pop (skid build).
  - TWO→ONE on pop without push.
  - In all other cases the state holds.

## Timing
- Reset values: `data_out` all ones, `data_valid` 0, `bit_count` 0, `overrun` 0, FSM EMPTY.
- Reset mid-word discards the partial word and any buffered words.
- All outputs are registered.
- `data_valid` rises on the clock edge that samples the final bit; the word is visible to the consumer in the following cycle. Latency is one clock from the last-bit strobe.
- `data_out` is stable while `data_valid`=1 and `data_ready`=0.
- Back-to-back words at one bit per clock are sustainable when the consumer keeps `data_ready`=1.
- `bit_count` updates on the same edge as the shift.

## Configuration
- `FLEX_STP_SKID_EN` defined:
  - output buffer is 2 entries, FIFO order.
  - overrun only when 2 entries are held and a push arrives without a pop.
- Not defined:
  - output buffer is 1 entry; state TWO is not built.
  - overrun whenever `data_valid`=1, `data_ready`=0 and a word completes.

## Test plan
- `NUM_BITS`=8, `SHIFT_MSB`=1: strobe bits 1,1,0,0,0,0,0,0 with `data_ready`=0 → one cycle after the 8th strobe `data_valid`=1, `data_out`=8'hC0, `bit_count`=0.
- `SHIFT_MSB`=0, same bit stream → `data_out`=8'h03.
- Overrun, skid disabled: send words 8'hC0 then 8'h3C, `data_ready` held 0 → `data_out` stays 8'hC0, `overrun`=1. Pulse `clear_overrun` → `overrun`=0. Pulse `data_ready` → `data_valid`=0.
- Skid enabled, same stimulus → no overrun. Successive pops return 8'hC0, then 8'h3C. A third word with no pops → `overrun`=1.
- Partial word and reset:
  - 5 strobes, then `frame_reset` coincident with a strobe, then 8 strobes of 8'hA5 → single word 8'hA5.
  - Assert `rst` after 3 strobes → all outputs at their reset values; the next 8 strobes yield a correct word.
- Word completion on the same cycle as `data_ready`, 1-entry buffer full with 8'h11, new word 8'h22 → next cycle `data_valid`=1, `data_out`=8'h22, `overrun`=0.
